// File: rtl/greedy_snake_dpb_w.sv
// Snake body list writer on DPB channel A.
// Keeps the body ring, moves/grows the head, then kicks the map reader.
module greedy_snake_dpb_w #(
  parameter logic [10:0] ADDRESS_STEP_N     = 11'd4,
  parameter logic [10:0] DATA_BEGIN_ADDRESS = 11'd4,
  parameter logic [10:0] INIT_LENGTH        = 11'd3,
  parameter logic [10:0] MAX_LENGTH         = 11'd64,
  parameter logic [3:0]  INIT_X             = 4'd5,
  parameter logic [3:0]  INIT_Y             = 4'd7,
  parameter logic [3:0]  RD_LAT             = 4'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [1:0]  dir,
  input  logic        grow,
  input  logic        game_over,
  input  logic        restart,
  output logic        busy,
  output logic        done,
  output logic [10:0] list_head_addr,
  output logic [10:0] list_length,
  output logic [7:0]  head_pos,
  output logic        map_en,
  input  logic        map_busy,
  output logic        i_a_clk_en,
  output logic        i_a_data_en,
  output logic        i_a_wr_en,
  output logic [10:0] i_a_address,
  output logic [7:0]  i_a_data,
  input  logic [7:0]  o_a_data
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CALC,
    S_SHIFT_RD,
    S_SHIFT_WR,
    S_WR_HEAD,
    S_KICK,
    S_WAIT
  } state_t;

  localparam logic [10:0] HEAD0 =
    DATA_BEGIN_ADDRESS + (INIT_LENGTH - 11'd1) * ADDRESS_STEP_N;
  localparam logic [3:0] X0 = INIT_X - INIT_LENGTH[3:0] + 4'd1;

  state_t      state;
  state_t      state_n;

  logic        init_go;
  logic [10:0] init_k;
  logic [10:0] init_addr;
  logic [10:0] head_addr;
  logic [10:0] end_addr;
  logic [10:0] length;
  logic [7:0]  hpos;
  logic [1:0]  dir_reg;
  logic        grow_q;
  logic        growing;
  logic [7:0]  new_pos;
  logic [10:0] cursor;
  logic [3:0]  rd_cnt;
  logic [7:0]  rd_data;
  logic        wait_first;

  logic [1:0]  dir_eff;
  logic [3:0]  mx;
  logic [3:0]  my;
  logic [10:0] head_next;
  logic [10:0] target;
  logic        init_last;
  logic        rd_done;
  logic        shift_last;
  logic        can_grow;

  assign i_a_clk_en     = 1'b1;
  assign i_a_data_en    = 1'b1;
  assign list_head_addr = head_addr;
  assign list_length    = length;
  assign head_pos       = hpos;

  // a request for the exact opposite direction keeps the old heading
  assign dir_eff    = ((dir ^ dir_reg) == 2'b01) ? dir_reg : dir;
  assign head_next  = head_addr + ADDRESS_STEP_N;
  assign init_last  = (init_k == INIT_LENGTH - 11'd1);
  assign rd_done    = (rd_cnt == RD_LAT);
  assign shift_last = (cursor == head_next);
  assign can_grow   = grow_q && (length < MAX_LENGTH);

  always_comb begin
    target = head_next;
    if (!growing && head_addr == end_addr)
      target = DATA_BEGIN_ADDRESS;
  end

  always_comb begin
    mx = hpos[7:4];
    my = hpos[3:0];
    unique case (1'b1)
      dir_eff == 2'd0: my = hpos[3:0] - 4'd1;
      dir_eff == 2'd1: my = hpos[3:0] + 4'd1;
      dir_eff == 2'd2: mx = hpos[7:4] - 4'd1;
      dir_eff == 2'd3: mx = hpos[7:4] + 4'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    map_en      = 1'b0;
    i_a_wr_en   = 1'b0;
    i_a_address = 11'd0;
    i_a_data    = 8'd0;
    unique case (state)
      S_INIT: begin
        if (init_go) begin
          i_a_wr_en   = 1'b1;
          i_a_address = init_addr;
          i_a_data    = {X0 + init_k[3:0], INIT_Y};
          if (init_last) state_n = S_KICK;
        end
      end
      S_IDLE: begin
        if (restart)
          state_n = S_INIT;
        else if (step && !game_over)
          state_n = S_CALC;
      end
      S_CALC: begin
        if (can_grow && head_addr != end_addr)
          state_n = S_SHIFT_RD;
        else
          state_n = S_WR_HEAD;
      end
      S_SHIFT_RD: begin
        i_a_address = cursor;
        if (rd_done) state_n = S_SHIFT_WR;
      end
      S_SHIFT_WR: begin
        i_a_wr_en   = 1'b1;
        i_a_address = cursor + ADDRESS_STEP_N;
        i_a_data    = rd_data;
        state_n     = shift_last ? S_WR_HEAD : S_SHIFT_RD;
      end
      S_WR_HEAD: begin
        i_a_wr_en   = 1'b1;
        i_a_address = target;
        i_a_data    = new_pos;
        state_n     = S_KICK;
      end
      S_KICK: begin
        map_en  = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (!wait_first && !map_busy) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_go    <= 1'b0;
      init_k     <= 11'd0;
      init_addr  <= DATA_BEGIN_ADDRESS;
      head_addr  <= HEAD0;
      end_addr   <= HEAD0;
      length     <= INIT_LENGTH;
      hpos       <= {INIT_X, INIT_Y};
      dir_reg    <= 2'd3;
      grow_q     <= 1'b0;
      growing    <= 1'b0;
      new_pos    <= 8'd0;
      cursor     <= 11'd0;
      rd_cnt     <= 4'd0;
      rd_data    <= 8'd0;
      wait_first <= 1'b0;
    end else begin
      unique case (state)
        S_INIT: begin
          if (!init_go) begin
            init_go <= 1'b1;
          end else begin
            init_k    <= init_k + 11'd1;
            init_addr <= init_addr + ADDRESS_STEP_N;
            if (init_last) begin
              head_addr <= init_addr;
              end_addr  <= init_addr;
              length    <= INIT_LENGTH;
              hpos      <= {INIT_X, INIT_Y};
              dir_reg   <= 2'd3;
            end
          end
        end
        S_IDLE: begin
          if (restart) begin
            init_go   <= 1'b0;
            init_k    <= 11'd0;
            init_addr <= DATA_BEGIN_ADDRESS;
          end else if (step && !game_over) begin
            grow_q <= grow;
          end
        end
        S_CALC: begin
          dir_reg <= dir_eff;
          new_pos <= {mx, my};
          growing <= can_grow;
          cursor  <= end_addr;
          rd_cnt  <= 4'd0;
        end
        S_SHIFT_RD: begin
          if (rd_done) begin
            rd_data <= o_a_data;
            rd_cnt  <= 4'd0;
          end else begin
            rd_cnt <= rd_cnt + 4'd1;
          end
        end
        S_SHIFT_WR: begin
          if (!shift_last)
            cursor <= cursor - ADDRESS_STEP_N;
        end
        S_WR_HEAD: begin
          head_addr <= target;
          hpos      <= new_pos;
          if (growing) begin
            length   <= length + 11'd1;
            end_addr <= end_addr + ADDRESS_STEP_N;
          end
        end
        S_KICK: wait_first <= 1'b1;
        S_WAIT: wait_first <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_greedy_snake_dpb_w.sv
// Randomized bench for greedy_snake_dpb_w.
// Body ring modelled as an array with insert-after-head growth.
module tb_greedy_snake_dpb_w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step;
  logic [1:0]  dir;
  logic        grow;
  logic        game_over;
  logic        restart;
  logic        busy;
  logic        done;
  logic [10:0] list_head_addr;
  logic [10:0] list_length;
  logic [7:0]  head_pos;
  logic        map_en;
  logic        map_busy;
  logic        i_a_clk_en;
  logic        i_a_data_en;
  logic        i_a_wr_en;
  logic [10:0] i_a_address;
  logic [7:0]  i_a_data;
  logic [7:0]  o_a_data;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [7:0] mem [0:2047];
  logic [7:0] rd_pipe [0:2];

  // reference body: slot k holds body[k], head at index h
  logic [7:0] body [0:64];
  int         len;
  int         h;
  logic [1:0] dreg;
  int         nsh;

  greedy_snake_dpb_w dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .step           (step),
    .dir            (dir),
    .grow           (grow),
    .game_over      (game_over),
    .restart        (restart),
    .busy           (busy),
    .done           (done),
    .list_head_addr (list_head_addr),
    .list_length    (list_length),
    .head_pos       (head_pos),
    .map_en         (map_en),
    .map_busy       (map_busy),
    .i_a_clk_en     (i_a_clk_en),
    .i_a_data_en    (i_a_data_en),
    .i_a_wr_en      (i_a_wr_en),
    .i_a_address    (i_a_address),
    .i_a_data       (i_a_data),
    .o_a_data       (o_a_data)
  );

  always #5 clk = ~clk;

  // DPB channel A with a 3-cycle read pipeline
  always @(posedge clk) begin
    rd_pipe[2] <= rd_pipe[1];
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[0] <= mem[i_a_address];
    if (i_a_wr_en) begin
      mem[i_a_address] <= i_a_data;
      wr_cnt <= wr_cnt + 1;
    end
  end
  assign o_a_data = rd_pipe[2];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    len  = 3;
    h    = 2;
    dreg = 2'd3;
    for (int k = 0; k < 3; k++)
      body[k] = {4'(5 - (2 - k)), 4'd7};
  endtask

  task automatic model_step(input logic [1:0] d, input logic g);
    int x;
    int y;
    logic [7:0] np;
    if ((d ^ dreg) != 2'b01) dreg = d;
    x = int'(body[h][7:4]);
    y = int'(body[h][3:0]);
    case (dreg)
      2'd0: y = (y + 15) % 16;
      2'd1: y = (y + 1) % 16;
      2'd2: x = (x + 15) % 16;
      default: x = (x + 1) % 16;
    endcase
    np = {4'(x), 4'(y)};
    if (g && len < 64) begin
      nsh = len - 1 - h;
      for (int i = len; i > h + 1; i--)
        body[i] = body[i-1];
      body[h+1] = np;
      h++;
      len++;
    end else begin
      nsh = 0;
      h = (h + 1) % len;
      body[h] = np;
    end
  endtask

  task automatic compare_model(input string tg);
    chk({tg, "_len"}, list_length, len);
    chk({tg, "_haddr"}, list_head_addr, 4 + 4 * h);
    chk({tg, "_hpos"}, head_pos, body[h]);
    for (int k = 0; k < len; k++)
      chk({tg, "_slot"}, mem[4 + 4 * k], body[k]);
  endtask

  task automatic check_reset();
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_map_en", map_en, 0);
    chk("rst_wr_en", i_a_wr_en, 0);
    chk("rst_addr", i_a_address, 0);
    chk("rst_data", i_a_data, 0);
    chk("rst_len", list_length, 3);
    chk("rst_haddr", list_head_addr, 12);
    chk("rst_hpos", head_pos, 8'h57);
  endtask

  // called at the negedge right after the triggering pulse
  task automatic run_update(input string tg, input int exp_lat,
                            input int exp_wr, input int wr0);
    int n;
    bit early;
    n = 0;
    early = 0;
    while (!map_en && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tg, "_kick"}, map_en, 1);
    if (exp_lat >= 0) chk({tg, "_lat"}, n, exp_lat);
    chk({tg, "_writes"}, wr_cnt - wr0, exp_wr);
    chk({tg, "_map_const"}, {i_a_clk_en, i_a_data_en}, 2'b11);
    @(negedge clk);
    map_busy = 1'b1;
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      if (done) early = 1;
    end
    chk({tg, "_done_early"}, early, 0);
    map_busy = 1'b0;
    #1;
    n = 0;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tg, "_done"}, done, 1);
    @(negedge clk);
    chk({tg, "_idle"}, busy, 0);
    compare_model(tg);
  endtask

  task automatic do_step(input string tg, input logic [1:0] d,
                         input logic g);
    int wr0;
    @(negedge clk);
    dir  = d;
    grow = g;
    step = 1'b1;
    wr0  = wr_cnt;
    model_step(d, g);
    @(negedge clk);
    step = 1'b0;
    run_update(tg, 2 + nsh * 5, nsh + 1, wr0);
  endtask

  initial begin
    int wr0;
    int n;
    bit seen;
    rst_n     = 1'b0;
    step      = 1'b0;
    dir       = 2'd3;
    grow      = 1'b0;
    game_over = 1'b0;
    restart   = 1'b0;
    map_busy  = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'd0;
    for (int i = 0; i < 3; i++) rd_pipe[i] = 8'd0;
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    model_init();
    run_update("init", -1, 3, wr_cnt);
    chk("init_m4", mem[4], 8'h37);
    chk("init_m12", mem[12], 8'h57);

    do_step("move_r", 2'd3, 1'b0);
    chk("move_r_m4", mem[4], 8'h67);
    chk("move_r_ha", list_head_addr, 4);
    do_step("reverse", 2'd2, 1'b0);
    chk("reverse_hp", head_pos, 8'h77);
    for (int i = 0; i < 10; i++) do_step("xwrap", 2'd3, 1'b0);
    for (int i = 0; i < 10; i++) do_step("ywrap", 2'd0, 1'b0);

    // grow with head at slot 0
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_init();
    run_update("restart", -1, 3, wr_cnt - 0);
    do_step("pre_grow", 2'd3, 1'b0);
    do_step("grow", 2'd3, 1'b1);
    chk("grow_len", list_length, 4);
    chk("grow_ha", list_head_addr, 8);

    for (int i = 0; i < 40; i++)
      do_step("rand", 2'($urandom_range(0, 3)),
              $urandom_range(0, 2) == 0);
    while (len < 64)
      do_step("fill", 2'($urandom_range(0, 3)), 1'b1);
    do_step("atmax", 2'($urandom_range(0, 3)), 1'b1);
    chk("atmax_len", list_length, 64);

    // step while game_over must be ignored
    @(negedge clk);
    game_over = 1'b1;
    step      = 1'b1;
    wr0       = wr_cnt;
    seen      = 0;
    @(negedge clk);
    step = 1'b0;
    repeat (6) begin
      if (busy) seen = 1;
      @(negedge clk);
    end
    game_over = 1'b0;
    chk("gover_busy", seen, 0);
    chk("gover_wr", wr_cnt - wr0, 0);

    // reset in the middle of a shift
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_init();
    run_update("restart2", -1, 3, wr_cnt);
    do_step("ms_pre", 2'd3, 1'b0);
    @(negedge clk);
    dir  = 2'd3;
    grow = 1'b1;
    step = 1'b1;
    wr0  = wr_cnt;
    @(negedge clk);
    step = 1'b0;
    n = 0;
    while (wr_cnt == wr0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ms_shift_wr", wr_cnt - wr0, 1);
    chk("ms_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
    run_update("ms_init", -1, 3, wr_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
